// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Two-requester round-robin arbiter and sequencer for the shared WIDTH-bit
// AND/OR/NOR logic unit. One operation is in flight at a time: accept,
// execute (operands presented to the unit), then hold the registered result
// on the response channel until it is taken.
//
// Build option:
//   LOGIC_UNIT_ARB_XOR_EN  when defined, op 3 returns XOR built from the unit
//                          outputs; otherwise op 3 completes with rsp_err=1
//                          and rsp_data=0.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   reqN_valid/ready/op/a/b     request channel for requester N (N=0,1)
//   lu_a, lu_b                  registered operands to the logic unit
//   lu_and, lu_or, lu_nor       combinational results from the logic unit
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_data, rsp_err   response payload
//   busy                        high while an operation is in flight
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate between requesters; accept latches id/op/operands
// EXEC  | operands on lu_a/lu_b; result captured at the end of the cycle
// RESP  | rsp_valid held with stable payload until rsp_ready
// ---------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] lu_and,
    input  logic [WIDTH-1:0] lu_or,
    input  logic [WIDTH-1:0] lu_nor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic             ptr_q;
    logic [1:0]       op_q;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             acc_id;
    logic             capture;
    logic [WIDTH-1:0] result;
    logic             result_err;

    // Pointer only matters when both requesters are valid.
    assign grant0 = req0_valid && (!req1_valid || (ptr_q == 1'b0));
    assign grant1 = req1_valid && (!req0_valid || (ptr_q == 1'b1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        acc_id     = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so ready reads 0 during reset even before
                // the first clock edge has initialised the state register.
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                if (req0_ready || req1_ready) begin
                    accept   = 1'b1;
                    acc_id   = req1_ready;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                capture  = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q == EXEC) || (state_q == RESP);

    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (op_q)
            2'd0: result = lu_and;
            2'd1: result = lu_or;
            2'd2: result = lu_nor;
            default: begin
`ifdef LOGIC_UNIT_ARB_XOR_EN
                // a^b: bits where neither both-set (and) nor both-clear (nor)
                result     = ~(lu_and | lu_nor);
                result_err = 1'b0;
`else
                result     = '0;
                result_err = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            op_q     <= 2'd0;
            lu_a     <= '0;
            lu_b     <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q  <= ~acc_id;
                rsp_id <= acc_id;
                op_q   <= acc_id ? req1_op : req0_op;
                lu_a   <= acc_id ? req1_a  : req0_a;
                lu_b   <= acc_id ? req1_b  : req0_b;
            end
            if (capture) begin
                rsp_data <= result;
                rsp_err  <= result_err;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [WIDTH-1:0] lu_a, lu_b, lu_and, lu_or, lu_nor;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;

    int errors = 0;
    int checks = 0;
    int id1_rsps;

    // behavioural stand-in for the shared logic unit
    assign lu_and = lu_a & lu_b;
    assign lu_or  = lu_a | lu_b;
    assign lu_nor = ~(lu_a | lu_b);

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .lu_a(lu_a), .lu_b(lu_b),
        .lu_and(lu_and), .lu_or(lu_or), .lu_nor(lu_nor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'd19999; req0_b = 32'd112345;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;

        // reset with a pending request: nothing accepted, outputs at reset values
        #1;
        chk("rst_ready0_pre", req0_ready, 1'b0);
        tick(); tick();
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lu_a", lu_a, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", rsp_id, 1'b0);

        // single request, AND
        rst_n = 1'b1;
        #1;
        chk("t1_ready0", req0_ready, 1'b1);
        tick();                                   // E0
        req0_valid = 1'b0;
        chk("t1_exec_busy", busy, 1'b1);
        chk("t1_exec_valid", rsp_valid, 1'b0);
        chk("t1_lu_a", lu_a, 32'd19999);
        chk("t1_lu_b", lu_b, 32'd112345);
        tick();                                   // E1
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_id", rsp_id, 1'b0);
        chk("t1_rsp_data", rsp_data, 32'h0000_0619);
        chk("t1_rsp_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk("t1_done_valid", rsp_valid, 1'b0);
        chk("t1_done_busy", busy, 1'b0);

        // contention: pointer now favours requester 1, grants alternate
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 32'd11; req0_b = 32'd10;
        req1_valid = 1'b1; req1_op = 2'd2; req1_a = 32'd0;  req1_b = 32'd0;
        for (int i = 0; i < 4; i++) begin
            logic eid;
            eid = (i % 2 == 0) ? 1'b1 : 1'b0;
            #1;
            chk("t2_ready0", req0_ready, !eid);
            chk("t2_ready1", req1_ready, eid);
            tick();
            chk("t2_ready_exec", {req0_ready, req1_ready}, 2'b00);
            tick();
            chk("t2_rsp_valid", rsp_valid, 1'b1);
            chk("t2_rsp_id", rsp_id, eid);
            chk("t2_rsp_data", rsp_data, eid ? 32'hFFFF_FFFF : 32'd11);
            chk("t2_ready_resp", {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // backpressure on requester 1
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'd0; req1_a = 32'd15; req1_b = 32'd15;
        #1;
        chk("t3_ready1", req1_ready, 1'b1);
        tick();
        req0_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", rsp_valid, 1'b1);
            chk("t3_hold_data", rsp_data, 32'd15);
            chk("t3_hold_id", rsp_id, 1'b1);
            chk("t3_hold_ready", {req0_ready, req1_ready}, 2'b00);
            chk("t3_hold_busy", busy, 1'b1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("t3_last_valid", rsp_valid, 1'b1);
        tick();
        chk("t3_done_valid", rsp_valid, 1'b0);
        chk("t3_done_busy", busy, 1'b0);

        // op 3
        req0_valid = 1'b1; req0_op = 2'd3; req0_a = 32'd8; req0_b = 32'd9;
        #1;
        chk("t4_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("t4_rsp_valid", rsp_valid, 1'b1);
`ifdef LOGIC_UNIT_ARB_XOR_EN
        chk("t4_rsp_data", rsp_data, 32'd1);
        chk("t4_rsp_err", rsp_err, 1'b0);
`else
        chk("t4_rsp_data", rsp_data, 32'd0);
        chk("t4_rsp_err", rsp_err, 1'b1);
`endif
        tick();

        // reset while in RESP; requester 0 served first so pointer would be 1
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 32'd5; req0_b = 32'd3;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("t5_in_resp", rsp_valid, 1'b1);
        chk("t5_rsp_data", rsp_data, 32'd7);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_valid", rsp_valid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_lu_a", lu_a, 32'd0);
        chk("t5_rst_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'd0; req0_a = 32'd3; req0_b = 32'd6;
        #1;
        chk("t5_ptr_ready0", req0_ready, 1'b1);
        chk("t5_ptr_ready1", req1_ready, 1'b0);

        // withdrawn request: req1 pulses only while busy
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        id1_rsps = 0;
        tick();                                   // accept requester 0
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        chk("t6_rsp_id", rsp_id, 1'b0);
        chk("t6_rsp_data", rsp_data, 32'd2);
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid && rsp_id) id1_rsps++;
            tick();
        end
        chk("t6_no_id1_rsp", id1_rsps, 0);
        chk("t6_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
